bn_batch_loader: RTL and testbench
==================================

# bn_batch_loader

Upstream feeder for the batch-normalisation block: collects a serial stream of N-bit activations and back-propagation gradients into complete 4-channel × 8-sample batches and presents each batch in parallel (x11..x48, x_bp11..x_bp48 order) with a valid/acknowledge handshake. Double-buffered, so one batch is filled while the previous one is held stable for the BN statistics/core stages.

## Interface
- N, 16, sample width in bits
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset
- in_data  in  N  stream sample
- in_valid  in  1  in_data is valid this cycle
- in_ready  out  1  loader can accept a sample this cycle
- clear  in  1  synchronous abort: discard the partially filled bank
- x_out  out  32*N  forward batch; sample k at bits [N*k +: N], k = 8*(c-1)+(s-1) for x_cs
- xbp_out  out  32*N  gradient batch; same packing as x_out for x_bp_cs
- out_valid  out  1  x_out/xbp_out hold a complete batch
- out_ack  in  1  consumer has taken the batch
- fill_count  out  6  samples accepted into the bank being filled (0..63)

## Operation
- Stream order per batch: 64 words; words 0..31 are forward samples (x11..x18, x21..x28, x31..x38, x41..x48), words 32..63 gradients in the same order.
- Two banks (A, B), each 64×N. Write pointer wr_bank, read pointer rd_bank, per-bank full flag; after reset wr_bank = rd_bank = A, both empty.
- Accept = in_valid & in_ready. in_ready = ~full[wr_bank] & ~clear.
- On accept: store in_data at index fill_count of wr_bank; fill_count increments. On accept at index 63: full[wr_bank] ← 1, wr_bank toggles, fill_count ← 0.
- out_valid = full[rd_bank]. x_out/xbp_out always drive bank rd_bank contents.
- out_ack while out_valid: full[rd_bank] ← 0, rd_bank toggles. out_ack while ~out_valid is ignored.
- clear: fill_count ← 0; partial data in wr_bank is discarded (contents need not be zeroed); full banks and rd_bank unaffected. clear has priority over a same-cycle accept (sample dropped; in_ready is 0 that cycle).
- Both banks full: in_ready = 0; the stream stalls without loss until out_ack.

## Timing
- Reset (reset = 0 at a clk edge): fill_count = 0, out_valid = 0, in_ready = 1 the following cycle, all bank storage and x_out/xbp_out = 0, pointers to A. Reset mid-fill or mid-handshake discards everything.
- Latency: out_valid rises the cycle after the 64th word is accepted; x_out/xbp_out are valid that same cycle.
- Output data held stable while out_valid = 1 and until the cycle after out_ack.
- Sustained throughput: one sample per cycle; with a consumer acking within 64 cycles, in_ready never deasserts.
- Completion of one bank and out_ack of the other in the same cycle: both take effect; wr_bank and rd_bank both toggle.
- In the cycle after out_ack frees the only full bank while the other is complete, out_valid stays 1 (other bank presented), no bubble.
- fill_count updates on the clock after each accept; wraps 63 → 0 only on bank completion.

## Test plan
- Reset then stream words 0x0000..0x003F back-to-back -> out_valid rises one cycle after word 0x003F; x_out[15:0] = 0x0000 (x11), x_out[511:496] = 0x001F (x48), xbp_out[15:0] = 0x0020, xbp_out[511:496] = 0x003F.
- Stream 192 words with out_ack held 0 -> in_ready drops after word 128; 64 words stall; ack once -> second batch (0x0040 base) presented next cycle, stream resumes with no lost word.
- Stream 20 words, assert clear with in_valid = 1 -> that word dropped, fill_count = 0; next 64 words form a batch starting at their first word.
- Continuous 64-cycle batches with out_ack pulsed the cycle each bank completes -> in_ready constant 1, out_valid one-cycle gap-free per batch, data matches stream.
- Assert reset = 0 after 40 words and with one bank full -> next cycle out_valid = 0, fill_count = 0, x_out = 0, in_ready = 1.
- out_ack pulsed with out_valid = 0 -> no pointer change; subsequent batch still lands in bank A and presents correctly.

Source files
------------

// File: rtl/bn_batch_loader.sv
// Double-buffered batch collector for the BN block: serial activations/gradients in,
// one 4-channel x 8-sample batch (forward + gradient) out with valid/ack handshake.
module bn_batch_loader #(
   parameter int N = 16
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [N-1:0]    in_data,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic            clear,
   output logic [32*N-1:0] x_out,
   output logic [32*N-1:0] xbp_out,
   output logic            out_valid,
   input  logic            out_ack,
   output logic [5:0]      fill_count
);

   // Bank word 0..31 = forward x11..x48, word 32..63 = gradients in the same order.
   logic [1:0][63:0][N-1:0] mem_q, mem_d;
   logic [1:0]              full_q, full_d;
   logic                    wr_bank_q, wr_bank_d;
   logic                    rd_bank_q, rd_bank_d;
   logic [5:0]              fill_q, fill_d;
   logic                    accept;

   always_comb begin
      mem_d     = mem_q;
      full_d    = full_q;
      wr_bank_d = wr_bank_q;
      rd_bank_d = rd_bank_q;
      fill_d    = fill_q;

      in_ready  = ~full_q[wr_bank_q] & ~clear;
      out_valid = full_q[rd_bank_q];
      accept    = in_valid & in_ready;

      if (clear) begin
         fill_d = 6'd0;
      end else if (accept) begin
         mem_d[wr_bank_q][fill_q] = in_data;
         if (fill_q == 6'd63) begin
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = ~wr_bank_q;
            fill_d            = 6'd0;
         end else begin
            fill_d = fill_q + 6'd1;
         end
      end

      // A completing bank is never the one being read, so both updates can land together.
      if (out_valid && out_ack) begin
         full_d[rd_bank_q] = 1'b0;
         rd_bank_d         = ~rd_bank_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         mem_q     <= '0;
         full_q    <= '0;
         wr_bank_q <= 1'b0;
         rd_bank_q <= 1'b0;
         fill_q    <= 6'd0;
      end else begin
         mem_q     <= mem_d;
         full_q    <= full_d;
         wr_bank_q <= wr_bank_d;
         rd_bank_q <= rd_bank_d;
         fill_q    <= fill_d;
      end
   end

   assign x_out      = mem_q[rd_bank_q][31:0];
   assign xbp_out    = mem_q[rd_bank_q][63:32];
   assign fill_count = fill_q;

endmodule

// File: tb/tb_bn_batch_loader.sv
// Directed bench for bn_batch_loader: one task per scenario, inline checks against
// hand-computed values.
module tb_bn_batch_loader;
   localparam int N = 16;

   logic            clk;
   logic            reset;
   logic [N-1:0]    in_data;
   logic            in_valid;
   logic            in_ready;
   logic            clear;
   logic [32*N-1:0] x_out;
   logic [32*N-1:0] xbp_out;
   logic            out_valid;
   logic            out_ack;
   logic [5:0]      fill_count;

   int n_pass  = 0;
   int n_total = 0;

   bn_batch_loader #(.N(N)) dut (
      .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .clear(clear), .x_out(x_out), .xbp_out(xbp_out),
      .out_valid(out_valid), .out_ack(out_ack), .fill_count(fill_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change and outputs are sampled 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic stream(input int base, input int n);
      for (int i = 0; i < n; i++) begin
         in_valid = 1'b1;
         in_data  = 16'(base + i);
         tick();
      end
      in_valid = 1'b0;
   endtask

   task automatic ack_once();
      out_ack = 1'b1;
      tick();
      out_ack = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      n_total++; if (fill_count !== 6'd0) $display("FAIL reset_fill got %0d want 0", fill_count); else n_pass++;
      n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else n_pass++;
      n_total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else n_pass++;
      n_total++; if (x_out !== '0 || xbp_out !== '0) $display("FAIL reset_data got x=%h xbp=%h want 0", x_out, xbp_out); else n_pass++;
   endtask

   task automatic test_basic();
      stream(0, 63);
      n_total++; if (out_valid !== 1'b0) $display("FAIL basic_early_valid got %b want 0", out_valid); else n_pass++;
      stream(63, 1);
      n_total++; if (out_valid !== 1'b1) $display("FAIL basic_valid got %b want 1", out_valid); else n_pass++;
      n_total++; if (x_out[15:0] !== 16'h0000) $display("FAIL basic_x11 got %h want 0000", x_out[15:0]); else n_pass++;
      n_total++; if (x_out[511:496] !== 16'h001F) $display("FAIL basic_x48 got %h want 001f", x_out[511:496]); else n_pass++;
      n_total++; if (xbp_out[15:0] !== 16'h0020) $display("FAIL basic_xbp11 got %h want 0020", xbp_out[15:0]); else n_pass++;
      n_total++; if (xbp_out[511:496] !== 16'h003F) $display("FAIL basic_xbp48 got %h want 003f", xbp_out[511:496]); else n_pass++;
      n_total++; if (fill_count !== 6'd0) $display("FAIL basic_fill got %0d want 0", fill_count); else n_pass++;
      ack_once();
      n_total++; if (out_valid !== 1'b0) $display("FAIL basic_after_ack got %b want 0", out_valid); else n_pass++;
   endtask

   task automatic test_stall();
      int leak;
      stream(0, 128);
      n_total++; if (in_ready !== 1'b0) $display("FAIL stall_ready got %b want 0", in_ready); else n_pass++;
      n_total++; if (out_valid !== 1'b1 || x_out[15:0] !== 16'h0000) $display("FAIL stall_batch1 got v=%b d=%h want 1/0000", out_valid, x_out[15:0]); else n_pass++;
      leak = 0;
      in_valid = 1'b1;
      in_data  = 16'd128;
      for (int i = 0; i < 64; i++) begin
         tick();
         if (in_ready !== 1'b0) leak++;
      end
      n_total++; if (leak !== 0 || fill_count !== 6'd0) $display("FAIL stall_hold got ready_cycles=%0d fill=%0d want 0/0", leak, fill_count); else n_pass++;
      ack_once();
      n_total++; if (out_valid !== 1'b1 || x_out[15:0] !== 16'h0040) $display("FAIL stall_batch2 got v=%b d=%h want 1/0040", out_valid, x_out[15:0]); else n_pass++;
      n_total++; if (in_ready !== 1'b1) $display("FAIL stall_resume got %b want 1", in_ready); else n_pass++;
      stream(128, 64);
      n_total++; if (x_out[511:496] !== 16'h005F || fill_count !== 6'd0) $display("FAIL stall_batch2_hold got d=%h fill=%0d want 005f/0", x_out[511:496], fill_count); else n_pass++;
      ack_once();
      n_total++; if (x_out[15:0] !== 16'h0080 || xbp_out[511:496] !== 16'h00BF) $display("FAIL stall_batch3 got %h/%h want 0080/00bf", x_out[15:0], xbp_out[511:496]); else n_pass++;
      ack_once();
      n_total++; if (out_valid !== 1'b0) $display("FAIL stall_drain got %b want 0", out_valid); else n_pass++;
   endtask

   task automatic test_clear();
      stream(16'h200, 20);
      n_total++; if (fill_count !== 6'd20) $display("FAIL clear_pre_fill got %0d want 20", fill_count); else n_pass++;
      clear    = 1'b1;
      in_valid = 1'b1;
      in_data  = 16'hDEAD;
      #1;
      n_total++; if (in_ready !== 1'b0) $display("FAIL clear_ready got %b want 0", in_ready); else n_pass++;
      tick();
      clear    = 1'b0;
      in_valid = 1'b0;
      n_total++; if (fill_count !== 6'd0) $display("FAIL clear_fill got %0d want 0", fill_count); else n_pass++;
      stream(16'h300, 64);
      n_total++; if (out_valid !== 1'b1 || x_out[15:0] !== 16'h0300) $display("FAIL clear_batch got v=%b d=%h want 1/0300", out_valid, x_out[15:0]); else n_pass++;
      n_total++; if (xbp_out[511:496] !== 16'h033F) $display("FAIL clear_batch_end got %h want 033f", xbp_out[511:496]); else n_pass++;
      ack_once();
   endtask

   task automatic test_back_to_back();
      int nb, drops, bad;
      nb = 0; drops = 0; bad = 0;
      for (int i = 0; i <= 192; i++) begin
         if (out_valid === 1'b1) begin
            if (x_out[15:0] !== 16'(16'h400 + 64*nb) || xbp_out[511:496] !== 16'(16'h400 + 64*nb + 63)) bad++;
            nb++;
         end
         out_ack  = out_valid;
         in_valid = (i < 192);
         in_data  = 16'(16'h400 + i);
         if (in_ready !== 1'b1) drops++;
         tick();
      end
      in_valid = 1'b0;
      out_ack  = 1'b0;
      n_total++; if (drops !== 0) $display("FAIL b2b_ready got %0d stalls want 0", drops); else n_pass++;
      n_total++; if (nb !== 3) $display("FAIL b2b_batches got %0d want 3", nb); else n_pass++;
      n_total++; if (bad !== 0) $display("FAIL b2b_data got %0d bad batches want 0", bad); else n_pass++;
      n_total++; if (out_valid !== 1'b0) $display("FAIL b2b_drain got %b want 0", out_valid); else n_pass++;
   endtask

   task automatic test_reset_mid();
      stream(16'h600, 104);
      n_total++; if (out_valid !== 1'b1 || fill_count !== 6'd40) $display("FAIL rmid_pre got v=%b fill=%0d want 1/40", out_valid, fill_count); else n_pass++;
      reset = 1'b0;
      tick();
      reset = 1'b1;
      n_total++; if (out_valid !== 1'b0 || fill_count !== 6'd0) $display("FAIL rmid_state got v=%b fill=%0d want 0/0", out_valid, fill_count); else n_pass++;
      n_total++; if (x_out !== '0 || xbp_out !== '0) $display("FAIL rmid_data got nonzero x=%h want 0", x_out); else n_pass++;
      n_total++; if (in_ready !== 1'b1) $display("FAIL rmid_ready got %b want 1", in_ready); else n_pass++;
   endtask

   task automatic test_ack_idle();
      out_ack = 1'b1;
      tick();
      tick();
      out_ack = 1'b0;
      n_total++; if (out_valid !== 1'b0) $display("FAIL idle_ack_valid got %b want 0", out_valid); else n_pass++;
      stream(16'h500, 64);
      n_total++; if (out_valid !== 1'b1 || x_out[15:0] !== 16'h0500) $display("FAIL idle_batch got v=%b d=%h want 1/0500", out_valid, x_out[15:0]); else n_pass++;
      n_total++; if (x_out[511:496] !== 16'h051F || xbp_out[15:0] !== 16'h0520) $display("FAIL idle_batch_words got %h/%h want 051f/0520", x_out[511:496], xbp_out[15:0]); else n_pass++;
      ack_once();
   endtask

   initial begin
      reset    = 1'b0;
      in_data  = '0;
      in_valid = 1'b0;
      clear    = 1'b0;
      out_ack  = 1'b0;
      test_reset();
      test_basic();
      test_stall();
      test_clear();
      test_back_to_back();
      test_reset_mid();
      test_ack_idle();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
